// File: rtl/prog_truth_table_if.sv
// Streaming evaluation and serial configuration bundle for prog_truth_table.
// The slave side is the truth-table block; the master side drives codes and table bits.
interface prog_truth_table_if #(
    parameter int N_IN = 3
);
    logic            in_valid;
    logic            in_ready;
    logic [N_IN-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic            out_data;
    logic            cfg_start;
    logic            cfg_valid;
    logic            cfg_bit;
    logic            cfg_busy;
    logic            cfg_done;

    modport master (
        output in_valid, in_data, out_ready, cfg_start, cfg_valid, cfg_bit,
        input  in_ready, out_valid, out_data, cfg_busy, cfg_done
    );

    modport slave (
        input  in_valid, in_data, out_ready, cfg_start, cfg_valid, cfg_bit,
        output in_ready, out_valid, out_data, cfg_busy, cfg_done
    );
endinterface

// File: rtl/prog_truth_table.sv
// Runtime-programmable N_IN-input Boolean function with a one-stage registered
// valid/ready output and a shadow table loaded serially and committed atomically.
module prog_truth_table #(
    parameter int                     N_IN       = 3,
    parameter logic [(1<<N_IN)-1:0]   INIT_TABLE = 8'hDE
) (
    input  logic                clk,
    input  logic                reset,
    prog_truth_table_if.slave   bus
);
    localparam int TBL_W = 1 << N_IN;
    localparam int CNT_W = N_IN + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_COMMIT
    } state_t;

    state_t             r_state;
    logic [TBL_W-1:0]   r_active;
    logic [TBL_W-1:0]   r_shadow;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_cfg_busy;
    logic               r_cfg_done;
    logic               r_vld_p1;
    logic               r_data_p1;
    logic               w_in_ready;
    logic               w_accept;

    assign w_in_ready = !r_vld_p1 || bus.out_ready;
    assign w_accept   = bus.in_valid && w_in_ready;

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_vld_p1;
    assign bus.out_data  = r_data_p1;
    assign bus.cfg_busy  = r_cfg_busy;
    assign bus.cfg_done  = r_cfg_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_active   <= INIT_TABLE;
            r_shadow   <= '0;
            r_cnt      <= '0;
            r_cfg_busy <= 1'b0;
            r_cfg_done <= 1'b0;
            r_vld_p1   <= 1'b0;
            r_data_p1  <= 1'b0;
        end else begin
            // ---- output stage p1: lookup uses the table as it stands this cycle
            if (w_accept) begin
                r_vld_p1  <= 1'b1;
                r_data_p1 <= r_active[bus.in_data];
            end else if (bus.out_ready) begin
                r_vld_p1  <= 1'b0;
            end

            r_cfg_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.cfg_start) begin
                        r_state    <= S_LOAD;
                        r_cnt      <= '0;
                        r_shadow   <= '0;
                        r_cfg_busy <= 1'b1;
                    end
                end
                S_LOAD: begin
                    // A restart wins over any bit presented in the same cycle
                    if (bus.cfg_start) begin
                        r_cnt    <= '0;
                        r_shadow <= '0;
                    end else if (bus.cfg_valid) begin
                        r_shadow <= {r_shadow[TBL_W-2:0], bus.cfg_bit};
                        r_cnt    <= r_cnt + 1'b1;
                        if (r_cnt == CNT_W'(TBL_W - 1)) begin
                            r_state    <= S_COMMIT;
                            r_cfg_busy <= 1'b0;
                            r_cfg_done <= 1'b1;
                        end
                    end
                end
                S_COMMIT: begin
                    r_active <= r_shadow;
                    r_cnt    <= '0;
                    if (bus.cfg_start) begin
                        r_state    <= S_LOAD;
                        r_shadow   <= '0;
                        r_cfg_busy <= 1'b1;
                    end else begin
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_cfg_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/prog_truth_table.md
Name: prog_truth_table

Overview:
- Parametrised successor to the fixed 3-input truth-table logic gates.
- Evaluates an N_IN-input Boolean function from a 2^N_IN-bit table that is runtime-loadable and held in registers.
- Streaming valid/ready input and output with one registered output stage.
- Serial configuration port loads a shadow table, which is committed atomically, so evaluation never sees a partially loaded table.

Parameters:
- N_IN, 3, number of logic inputs (1..6).
- INIT_TABLE, 8'hDE (width 2^N_IN), active table after reset; bit i = output for input code i.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  input code valid.
- in_ready  out  1  block can accept in_data this cycle.
- in_data  in  N_IN  input code {in1 (MSB) .. inN (LSB)}.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  1  function value.
- cfg_start  in  1  begin (or restart) a table load.
- cfg_valid  in  1  cfg_bit valid this cycle.
- cfg_bit  in  1  serial table bit, MSB (index 2^N_IN-1) first.
- cfg_busy  out  1  load in progress.
- cfg_done  out  1  one-cycle pulse when the new table is committed.

Behaviour:
- Reset (synchronous, active-high, highest priority):
  - active table = INIT_TABLE; shadow table = 0; bit counter = 0.
  - FSM = IDLE.
  - out_valid = 0, out_data = 0, cfg_busy = 0, cfg_done = 0.
  - Any in-flight result or partial load is discarded.
- Evaluation path:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept when in_valid && in_ready. On the next cycle: out_valid = 1 and out_data = active_table[in_data], using the active table as it stood in the accept cycle.
  - Latency is 1 cycle. Full throughput: 1 result/cycle while out_ready = 1.
  - Hold: while out_valid && !out_ready, out_data, out_valid and in_ready = 0 stay frozen.
  - out_valid clears when the result is taken (out_ready = 1) and no new input is accepted in that cycle.
  - Evaluation runs independently of configuration and is never stalled by a load.
- Configuration FSM:
  - IDLE:
    - cfg_start → LOAD; counter = 0; cfg_busy = 1 from the next cycle.
    - cfg_valid in IDLE is ignored.
  - LOAD:
    - Each cycle with cfg_valid: shadow = {shadow[2^N_IN-2:0], cfg_bit}; counter++.
    - When the counter reaches 2^N_IN - 1 and a valid bit arrives → COMMIT.
    - cfg_start during LOAD restarts the load: counter = 0, shadow cleared, and any cfg_bit in that cycle is ignored.
  - COMMIT (1 cycle):
    - active table = shadow; cfg_done = 1; cfg_busy = 0; then → IDLE.
    - An input accepted in the COMMIT cycle still uses the old table.
    - The first input using the new table is one accepted in the cycle after COMMIT.
    - cfg_start in COMMIT is honoured after the commit: → LOAD next cycle instead of IDLE.
- Widths:
  - Counter is ceil(log2(2^N_IN)) + 1 bits and wraps only via restart or commit.
  - in_data indexes the table directly; there are no illegal codes.

Test Plan:
- Reset, then stream codes 0..7 with out_ready = 1 → out_data sequence 0,1,1,1,1,0,1,1, each 1 cycle after its accept; out_valid high for 8 consecutive cycles.
- Backpressure:
  - Stimulus: accept code 5, then hold out_ready = 0 for 4 cycles while in_valid = 1 with code 1.
  - Response: out_data stays 0, in_ready = 0 throughout, and code 1 is accepted only in the cycle out_ready rises, giving out_data = 1 one cycle later.
- Load 8'h96 (XOR3) serially with 2 idle cycles inserted between bits, then evaluate all codes:
  - cfg_busy is high during the load; cfg_done pulses exactly once.
  - Outputs are 0,1,1,0,1,0,0,1.
- Commit boundary:
  - Stimulus: table 8'hDE active; present code 0 in the COMMIT cycle of an 8'hFF load, then code 0 again on the next cycle.
  - Response: out_data = 0, then 1.
- Restart:
  - Stimulus: cfg_start, 5 bits of 1, cfg_start again, then 8 bits of 8'h01.
  - Response: active table = 8'h01; code 0 → 1 and code 7 → 0; cfg_done pulses once.
- Reset mid-operation:
  - Stimulus: assert reset after 3 bits of a load and while out_valid = 1 is held by backpressure.
  - Response: next cycle out_valid = 0, cfg_busy = 0, table = 8'hDE (code 5 → 0).
